frame_writer_rgb888: RTL and testbench
======================================

Name: frame_writer_rgb888

Overview:
- Write-side counterpart of the 3x3 window reader: takes the processed RGB888 pixel stream (valid-qualified, raster order) from the convolution stage and writes it sequentially into the output frame BRAM.
- Has a small elastic FIFO, so upstream bursts survive cycles where the shared BRAM write port is not granted.
- Generates chip-select, write-enable, address and data, and signals frame completion.

Parameters:
DATA_W, 24, pixel width (RGB888)
ADDR_W, 17, BRAM address width
WIDTH, 480, pixels per row
HEIGHT, 272, rows per frame
DEPTH, 130560, pixels per frame (WIDTH*HEIGHT)
FIFO_DEPTH, 4, elastic buffer entries (power of two)

Ports:
iClk  input  1  clock
iRst  input  1  reset, asynchronous, active-high
iEn  input  1  global enable; low freezes all state
iStart  input  1  start-of-frame request, sampled in IDLE only
iValid  input  1  upstream pixel valid
iPixel  input  DATA_W  upstream pixel
iGrant  input  1  BRAM write port granted this cycle
oCs  output  1  BRAM chip select (registered)
oWe  output  1  BRAM write enable (registered, equals oCs)
oAddr  output  ADDR_W  BRAM write address (registered)
oData  output  DATA_W  BRAM write data (registered)
oBusy  output  1  high whenever the state is not IDLE
oFrameDone  output  1  one-cycle pulse with the final write
oOverflow  output  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Reset (any time, including mid-frame):
  - state=IDLE; FIFO empty; all counters 0.
  - oCs, oWe, oFrameDone, oOverflow = 0; oAddr = 0; oData = 0.
- iEn low: no state, FIFO, counter or output register updates, except that oCs, oWe and oFrameDone are driven 0 in that cycle. iValid is ignored.
- States:
  - IDLE: iStart -> RUN. Clears the accept count, write address and oOverflow.
  - RUN: accept pixels. When the accept count reaches DEPTH -> DRAIN.
  - DRAIN: accept nothing; keep writing. When the final write issues -> DONE.
  - DONE: one cycle, then IDLE.
- iStart outside IDLE is ignored. iValid outside RUN is ignored and does not set oOverflow.
- Push:
  - In RUN with iValid, push when FIFO count < FIFO_DEPTH, or when a pop occurs in the same cycle (full FIFO plus simultaneous pop accepts the pixel).
  - Otherwise the pixel is dropped and oOverflow is set. It stays set until the next IDLE->RUN transition.
  - A dropped pixel still increments the accept count, so frame length is always DEPTH input beats.
- Pop: happens when the FIFO is non-empty and iGrant is high (RUN or DRAIN). A pop loads the output registers at that edge:
  - oCs = oWe = 1
  - oData = head entry
  - oAddr = write address
  - the write address then increments.
  - In cycles with no pop, oCs and oWe are 0; oAddr and oData hold their last values.
- Latency: pixel valid in cycle t, FIFO empty, iGrant high -> oCs/oWe high in cycle t+2 for exactly one cycle.
- Final write:
  - The write with address DEPTH-1 asserts oFrameDone in the same cycle as its oCs.
  - The write address wraps to 0. No write is ever issued at an address >= DEPTH.
- Write order is strictly FIFO order. Addresses are contiguous, increment by 1, and never skip, including across dropped pixels (the drop shortens the data, not the address sequence).
- Frame end with drops: the FIFO drains after the accept count reaches DEPTH. If drops occurred, fewer than DEPTH writes exist, so DRAIN ends when the FIFO is empty instead: go to DONE, and pulse oFrameDone in the cycle after the FIFO empties.
- Counter widths: the accept count and write address are ADDR_W bits. The FIFO count is clog2(FIFO_DEPTH)+1 bits. There is no arithmetic overflow, because all comparisons are against DEPTH-1.

Test Plan:
1. WIDTH=4, HEIGHT=2, DEPTH=8; iStart, then 8 back-to-back pixels 0x000001..0x000008, iGrant=1 -> 8 writes at addresses 0..7 with matching data; first oCs 2 cycles after the first iValid; oFrameDone coincident with address 7; oBusy drops one cycle later; oOverflow=0.
2. Same frame, iGrant=0 for the first 6 pixels -> 4 buffered, pixels 5 and 6 dropped, oOverflow=1. After grant: writes 1,2,3,4,7,8 at addresses 0..5; DONE when the FIFO empties; oFrameDone pulses once.
3. FIFO full with iGrant=1 and iValid=1 in the same cycle -> pixel accepted, no overflow; head written.
4. iEn held low for 3 cycles mid-frame -> oCs=0 during the stall, no counter movement; the address sequence continues unbroken afterwards.
5. iRst pulsed after 3 writes -> all outputs 0 and state IDLE; a new iStart restarts at address 0.
6. iStart asserted during RUN -> ignored; address sequence and oFrameDone timing unchanged.

Source files
------------

// File: rtl/frame_writer_rgb888.sv
// Sequential frame writer: buffers a valid-qualified RGB888 raster stream in a small
// elastic FIFO and issues contiguous BRAM writes whenever the shared write port is granted.
module frame_writer_rgb888 #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 17,
    parameter int WIDTH      = 480,
    parameter int HEIGHT     = 272,
    parameter int DEPTH      = WIDTH * HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iStart,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iPixel,
    input  logic              iGrant,
    output logic              oCs,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic              oOverflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   accept_q, waddr_q, addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                cs_q, done_q, ovf_q;
    logic                pop_s, push_s, drop_s, start_s, done_d;

    // Handshake decode, next state and frame-done pulse.
    always_comb begin
        state_d = state_q;
        pop_s   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (count_q != '0) && iGrant;
        push_s  = (state_q == S_RUN) && iValid && ((count_q < FIFO_FULL) || pop_s);
        drop_s  = (state_q == S_RUN) && iValid && !push_s;
        start_s = (state_q == S_IDLE) && iStart;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStart) state_d = S_RUN;
                else        state_d = S_IDLE;
            end
            S_RUN: begin
                if (iValid && (accept_q == LAST_ADDR)) state_d = S_DRAIN;
                else                                    state_d = S_RUN;
            end
            S_DRAIN: begin
                // An empty FIFO here means drops shortened the frame: finish without the last address.
                if (pop_s && (waddr_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (count_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)     state_q <= S_IDLE;
        else if (iEn) state_q <= state_d;
    end

    // FIFO storage; only valid entries are ever read, so no reset is needed.
    always_ff @(posedge iClk) begin
        if (iEn && push_s) fifo_q[wr_ptr_q] <= iPixel;
    end

    // FIFO pointers, frame counters and registered BRAM outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            accept_q <= '0;
            waddr_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cs_q     <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (!iEn) begin
            cs_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (start_s)                            accept_q <= '0;
            else if ((state_q == S_RUN) && iValid)  accept_q <= accept_q + ADDR_W'(1);
            if (start_s)    waddr_q <= '0;
            else if (pop_s) waddr_q <= (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_W'(1);
            if (start_s)     ovf_q <= 1'b0;
            else if (drop_s) ovf_q <= 1'b1;
            cs_q   <= pop_s;
            done_q <= done_d;
            if (pop_s) begin
                addr_q <= waddr_q;
                data_q <= fifo_q[rd_ptr_q];
            end
        end
    end

    assign oCs        = cs_q;
    assign oWe        = cs_q;
    assign oAddr      = addr_q;
    assign oData      = data_q;
    assign oFrameDone = done_q;
    assign oOverflow  = ovf_q;
    assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_writer_rgb888.sv
// Self-checking bench for frame_writer_rgb888: a queue-based frame model is compared with
// the DUT outputs every cycle, plus directed frames pinned with literal write logs.
module tb_frame_writer_rgb888;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 8;
    localparam int FD     = 4;

    logic              iClk = 1'b0;
    logic              iRst = 1'b1;
    logic              iEn = 1'b1, iStart = 1'b0, iValid = 1'b0, iGrant = 1'b0;
    logic [DATA_W-1:0] iPixel = '0;
    logic              oCs, oWe, oBusy, oFrameDone, oOverflow;
    logic [ADDR_W-1:0] oAddr;
    logic [DATA_W-1:0] oData;

    frame_writer_rgb888 #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIDTH(4), .HEIGHT(2), .DEPTH(DEPTH), .FIFO_DEPTH(FD)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iValid(iValid),
        .iPixel(iPixel), .iGrant(iGrant), .oCs(oCs), .oWe(oWe), .oAddr(oAddr),
        .oData(oData), .oBusy(oBusy), .oFrameDone(oFrameDone), .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    int checks = 0, errors = 0, cyc_n = 0;

    // Model: phase 0 idle, 1 accepting, 2 draining, 3 done
    int                m_phase = 0, m_acc = 0, m_addr = 0, e_addr = 0;
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] e_data = '0;
    bit                m_ovf = 1'b0, e_cs = 1'b0, e_fd = 1'b0;

    int                log_a[$];
    logic [DATA_W-1:0] log_d[$];
    int                fd_n = 0, fd_addr = -1, first_cs = -1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    always @(posedge iClk) cyc_n <= cyc_n + 1;

    // Reference model of the frame writer built from queues and counts.
    always @(posedge iClk or posedge iRst) begin
        bit was_empty, pop, push;
        if (iRst) begin
            m_phase = 0; m_acc = 0; m_addr = 0; m_ovf = 0;
            m_q.delete();
            e_cs = 0; e_fd = 0; e_addr = 0; e_data = '0;
        end else if (!iEn) begin
            e_cs = 0; e_fd = 0;
        end else begin
            was_empty = (m_q.size() == 0);
            pop  = (m_phase == 1 || m_phase == 2) && !was_empty && iGrant;
            push = (m_phase == 1) && iValid && (m_q.size() < FD || pop);
            e_cs = pop; e_fd = 0;
            if (pop) begin
                e_addr = m_addr;
                e_data = m_q.pop_front();
                e_fd   = (m_addr == DEPTH - 1);
                m_addr = (m_addr + 1) % DEPTH;
            end
            if (push) m_q.push_back(iPixel);
            case (m_phase)
                0: if (iStart) begin m_phase = 1; m_acc = 0; m_addr = 0; m_ovf = 0; end
                1: if (iValid) begin
                       if (!push) m_ovf = 1;
                       m_acc++;
                       if (m_acc == DEPTH) m_phase = 2;
                   end
                2: if (e_fd) m_phase = 3;
                   else if (was_empty) begin m_phase = 3; e_fd = 1; end
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, plus a log of issued writes.
    always @(negedge iClk) begin
        cmp("cs", 32'(oCs), 32'(e_cs));
        cmp("we", 32'(oWe), 32'(e_cs));
        cmp("frame_done", 32'(oFrameDone), 32'(e_fd));
        cmp("overflow", 32'(oOverflow), 32'(m_ovf));
        cmp("busy", 32'(oBusy), 32'(m_phase != 0));
        cmp("addr", 32'(oAddr), 32'(e_addr));
        cmp("data", 32'(oData), 32'(e_data));
        if (oCs) begin
            if (log_a.size() == 0) first_cs = cyc_n;
            log_a.push_back(int'(oAddr));
            log_d.push_back(oData);
        end
        if (oFrameDone) begin
            fd_n++;
            fd_addr = oCs ? int'(oAddr) : -1;
        end
    end

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] px, input bit v, input bit g);
        iValid = v; iPixel = px; iGrant = g;
        cyc();
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete();
        fd_n = 0; fd_addr = -1; first_cs = -1;
    endtask

    task automatic start_frame();
        clear_logs();
        iStart = 1'b1; iValid = 1'b0;
        cyc();
        iStart = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        iValid = 1'b0;
        while (oBusy && n < max_cyc) begin
            cyc();
            n++;
        end
        checks++;
        if (oBusy) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", max_cyc);
        end
        cyc();
    endtask

    task automatic check_log(input string nm, input logic [DATA_W-1:0] exp_d[$]);
        cmp({nm, "_count"}, 32'(log_a.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < log_a.size(); i++) begin
            cmp({nm, "_addr"}, 32'(log_a[i]), 32'(i));
            cmp({nm, "_data"}, 32'(log_d[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] exp_q[$];
        int t0, sent;
        bit v, en;

        cyc(); cyc();
        iRst = 1'b0;
        cyc();

        // Back-to-back frame with constant grant
        start_frame();
        t0 = cyc_n;
        for (int i = 1; i <= 8; i++) send(24'(i), 1'b1, 1'b1);
        wait_idle(50);
        exp_q = {};
        for (int i = 1; i <= 8; i++) exp_q.push_back(24'(i));
        check_log("t1", exp_q);
        cmp("t1_latency", 32'(first_cs - t0), 32'd2);
        cmp("t1_fd_count", 32'(fd_n), 32'd1);
        cmp("t1_fd_addr", 32'(fd_addr), 32'd7);
        cmp("t1_overflow", 32'(oOverflow), 32'd0);

        // Grant withheld: pixels 5 and 6 dropped
        start_frame();
        for (int i = 1; i <= 6; i++) send(24'(i), 1'b1, 1'b0);
        send(24'd7, 1'b1, 1'b1);
        send(24'd8, 1'b1, 1'b1);
        wait_idle(50);
        exp_q = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd7, 24'd8};
        check_log("t2", exp_q);
        cmp("t2_overflow", 32'(oOverflow), 32'd1);
        cmp("t2_fd_count", 32'(fd_n), 32'd1);

        // Full FIFO with simultaneous pop accepts the pixel
        start_frame();
        for (int i = 1; i <= 4; i++) send(24'(i), 1'b1, 1'b0);
        for (int i = 5; i <= 8; i++) send(24'(i), 1'b1, 1'b1);
        wait_idle(50);
        exp_q = {};
        for (int i = 1; i <= 8; i++) exp_q.push_back(24'(i));
        check_log("t3", exp_q);
        cmp("t3_overflow", 32'(oOverflow), 32'd0);

        // Enable stall mid-frame plus an ignored start request
        start_frame();
        for (int i = 1; i <= 3; i++) send(24'(i), 1'b1, 1'b1);
        iEn = 1'b0;
        for (int i = 0; i < 3; i++) send(24'h99, 1'b1, 1'b1);
        iEn = 1'b1;
        send(24'd4, 1'b1, 1'b1);
        iStart = 1'b1;
        send(24'd5, 1'b1, 1'b1);
        iStart = 1'b0;
        for (int i = 6; i <= 8; i++) send(24'(i), 1'b1, 1'b1);
        wait_idle(50);
        check_log("t4", exp_q);
        cmp("t4_fd_addr", 32'(fd_addr), 32'd7);

        // Reset mid-frame, then a clean restart at address 0
        start_frame();
        for (int i = 1; i <= 5; i++) send(24'(i), 1'b1, 1'b1);
        iValid = 1'b0;
        iRst = 1'b1;
        #1;
        cmp("rst_cs", 32'(oCs), 32'd0);
        cmp("rst_addr", 32'(oAddr), 32'd0);
        cmp("rst_data", 32'(oData), 32'd0);
        cmp("rst_busy", 32'(oBusy), 32'd0);
        cyc();
        iRst = 1'b0;
        cyc();
        start_frame();
        for (int i = 1; i <= 8; i++) send(24'(i + 16), 1'b1, 1'b1);
        wait_idle(50);
        exp_q = {};
        for (int i = 1; i <= 8; i++) exp_q.push_back(24'(i + 16));
        check_log("t5", exp_q);

        // Randomized frames: gaps, grant stalls, enable stalls, stray starts
        for (int f = 0; f < 30; f++) begin
            start_frame();
            sent = 0;
            while (sent < DEPTH) begin
                v  = ($urandom_range(0, 3) != 0);
                en = ($urandom_range(0, 9) != 0);
                iEn = en;
                iStart = ($urandom_range(0, 15) == 0);
                send(24'($urandom), v, ($urandom_range(0, 9) < 6));
                if (v && en) sent++;
            end
            iStart = 1'b0;
            iEn = 1'b1;
            iGrant = 1'b1;
            wait_idle(100);
            cmp("rand_fd_count", 32'(fd_n), 32'd1);
            for (int i = 0; i < log_a.size(); i++) cmp("rand_addr_seq", 32'(log_a[i]), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
